// File: rtl/controlador_busca.sv
// Search sequencer: seeds the origin, expands approved nodes and
// serialises neighbour updates/deactivations into the evaluator.
module controlador_busca #(
  parameter int NUM_NA          = 4,
  parameter int ADR_WIDTH       = 5,
  parameter int DISTANCIA_WIDTH = 5,
  parameter int CUSTO_WIDTH     = 4,
  parameter int NUM_VIZ         = 4,
  parameter int UPDATE_GAP      = 2,
  parameter int TIMEOUT         = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_in,
  input  logic [ADR_WIDTH-1:0]                 origem_in,
  input  logic [ADR_WIDTH-1:0]                 destino_in,
  input  logic [NUM_NA-1:0]                    aa_aprovado_in,
  input  logic [ADR_WIDTH*NUM_NA-1:0]          aa_endereco_in,
  input  logic [DISTANCIA_WIDTH*NUM_NA-1:0]    aa_distancia_in,
  output logic                                 viz_req_out,
  output logic [ADR_WIDTH-1:0]                 viz_endereco_out,
  input  logic                                 viz_valido_in,
  input  logic [ADR_WIDTH-1:0]                 viz_endereco_in,
  input  logic [CUSTO_WIDTH-1:0]               viz_custo_in,
  input  logic                                 viz_ultimo_in,
  output logic                                 cb_atualizar_out,
  output logic                                 cb_desativar_out,
  output logic [ADR_WIDTH-1:0]                 cb_endereco_out,
  output logic [ADR_WIDTH-1:0]                 cb_anterior_out,
  output logic [CUSTO_WIDTH-1:0]               cb_menor_vizinho_out,
  output logic [DISTANCIA_WIDTH-1:0]           cb_distancia_out,
  output logic                                 cb_ocupado_out,
  output logic                                 cb_encontrado_out,
  output logic                                 cb_falha_out,
  output logic [7:0]                           cb_iteracoes_out
);

  localparam int PW = $clog2(NUM_VIZ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(UPDATE_GAP + 2);
  localparam int DW = DISTANCIA_WIDTH;

  typedef enum logic [2:0] {
    OCIOSO, SEMEAR, GAP, AGUARDA,
    SELECIONA, EXPANDE, ATUALIZA, DESATIVA
  } estado_t;

  estado_t estado, prox, retorno, retorno_d, alvo;
  logic    pulso;

  logic [ADR_WIDTH-1:0] origem, destino, exp_adr;
  logic [DW-1:0]        exp_dist;
  logic [GW-1:0]        gap_cnt;
  logic [TW-1:0]        to_cnt;
  logic                 ovf;

  logic [ADR_WIDTH-1:0]   fifo_adr   [NUM_VIZ];
  logic [CUSTO_WIDTH-1:0] fifo_custo [NUM_VIZ];
  logic [PW:0]            wr_ptr, rd_ptr;
  logic                   vazio, cheio, push, drop, pop;

  logic                 algum, fim_to, fim_gap, achou;
  logic [ADR_WIDTH-1:0] sel_adr;
  logic [DW-1:0]        sel_dist;
  logic [CUSTO_WIDTH-1:0] cab_custo;
  logic [ADR_WIDTH-1:0] cab_adr;
  logic [DW:0]          soma;

  logic                   viz_req_d, atu_d, des_d;
  logic                   ocu_d, enc_d, fal_d;
  logic [ADR_WIDTH-1:0]   viz_end_d, end_d, ant_d;
  logic [CUSTO_WIDTH-1:0] custo_d;
  logic [DW-1:0]          dist_d;
  logic [7:0]             it_d;

  // Lowest-index approved slot wins.
  always_comb begin
    sel_adr  = '0;
    sel_dist = '0;
    for (int i = NUM_NA - 1; i >= 0; i--) begin
      if (aa_aprovado_in[i]) begin
        sel_adr  = aa_endereco_in[ADR_WIDTH*i +: ADR_WIDTH];
        sel_dist = aa_distancia_in[DW*i +: DW];
      end
    end
  end

  assign algum   = |aa_aprovado_in;
  assign fim_to  = (to_cnt == TW'(TIMEOUT - 1));
  assign fim_gap = (gap_cnt == GW'(UPDATE_GAP - 1));
  assign achou   = (exp_adr == destino);

  assign vazio = (wr_ptr == rd_ptr);
  assign cheio = ((wr_ptr - rd_ptr) == (PW+1)'(NUM_VIZ));
  assign push  = (estado == EXPANDE) && viz_valido_in && !cheio;
  assign drop  = (estado == EXPANDE) && viz_valido_in && cheio;
  assign pop   = (estado == ATUALIZA) && !vazio;

  assign cab_adr   = fifo_adr[rd_ptr[PW-1:0]];
  assign cab_custo = fifo_custo[rd_ptr[PW-1:0]];
  assign soma      = {1'b0, exp_dist} + (DW+1)'(cab_custo);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_adr[wr_ptr[PW-1:0]]   <= viz_endereco_in;
      fifo_custo[wr_ptr[PW-1:0]] <= viz_custo_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado   <= OCIOSO;
      retorno  <= OCIOSO;
      origem   <= '0;
      destino  <= '0;
      exp_adr  <= '0;
      exp_dist <= '0;
      gap_cnt  <= '0;
      to_cnt   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ovf      <= 1'b0;
    end else begin
      estado  <= prox;
      retorno <= retorno_d;
      gap_cnt <= (estado == GAP) ? gap_cnt + 1'b1 : '0;
      to_cnt  <= (estado == AGUARDA) ? to_cnt + 1'b1 : '0;
      if (estado == OCIOSO && start_in) begin
        origem  <= origem_in;
        destino <= destino_in;
      end
      if (estado == AGUARDA && algum) begin
        exp_adr  <= sel_adr;
        exp_dist <= sel_dist;
      end
      if (estado == SELECIONA) ovf <= 1'b0;
      if (drop) ovf <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    prox      = estado;
    retorno_d = retorno;
    alvo      = estado;
    pulso     = 1'b0;
    unique case (estado)
      OCIOSO:    if (start_in) prox = SEMEAR;
      SEMEAR:    begin pulso = 1'b1; alvo = AGUARDA; end
      GAP:       if (fim_gap) prox = retorno;
      AGUARDA: begin
        if (algum)       prox = SELECIONA;
        else if (fim_to) prox = OCIOSO;
      end
      SELECIONA: prox = achou ? OCIOSO : EXPANDE;
      EXPANDE:   if (viz_ultimo_in) prox = ATUALIZA;
      ATUALIZA: begin
        if (!vazio)   begin pulso = 1'b1; alvo = ATUALIZA; end
        else if (ovf) prox = OCIOSO;
        else          prox = DESATIVA;
      end
      DESATIVA:  begin pulso = 1'b1; alvo = AGUARDA; end
      default:   prox = OCIOSO;
    endcase
    // Every pulse is followed by the idle gap, when there is one.
    if (pulso) begin
      if (UPDATE_GAP == 0) begin
        prox = alvo;
      end else begin
        prox      = GAP;
        retorno_d = alvo;
      end
    end
  end

  always_comb begin
    viz_req_d = 1'b0;
    atu_d     = 1'b0;
    des_d     = 1'b0;
    viz_end_d = viz_endereco_out;
    end_d     = cb_endereco_out;
    ant_d     = cb_anterior_out;
    custo_d   = cb_menor_vizinho_out;
    dist_d    = cb_distancia_out;
    ocu_d     = cb_ocupado_out;
    enc_d     = cb_encontrado_out;
    fal_d     = cb_falha_out;
    it_d      = cb_iteracoes_out;
    unique case (estado)
      OCIOSO: if (start_in) begin
        enc_d = 1'b0;
        fal_d = 1'b0;
        it_d  = '0;
        ocu_d = 1'b1;
      end
      SEMEAR: begin
        atu_d   = 1'b1;
        end_d   = origem;
        ant_d   = origem;
        custo_d = '0;
        dist_d  = '0;
      end
      AGUARDA: if (!algum && fim_to) begin
        fal_d = 1'b1;
        ocu_d = 1'b0;
      end
      SELECIONA: begin
        if (achou) begin
          enc_d = 1'b1;
          ocu_d = 1'b0;
        end else begin
          viz_req_d = 1'b1;
          viz_end_d = exp_adr;
          it_d = (cb_iteracoes_out == 8'hFF) ? 8'hFF
                                              : cb_iteracoes_out + 8'd1;
        end
      end
      ATUALIZA: begin
        if (!vazio) begin
          atu_d   = 1'b1;
          end_d   = cab_adr;
          ant_d   = exp_adr;
          custo_d = cab_custo;
          dist_d  = soma[DW] ? '1 : soma[DW-1:0];
        end else if (ovf) begin
          fal_d = 1'b1;
          ocu_d = 1'b0;
        end
      end
      DESATIVA: begin
        des_d = 1'b1;
        end_d = exp_adr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      viz_req_out          <= 1'b0;
      viz_endereco_out     <= '0;
      cb_atualizar_out     <= 1'b0;
      cb_desativar_out     <= 1'b0;
      cb_endereco_out      <= '0;
      cb_anterior_out      <= '0;
      cb_menor_vizinho_out <= '0;
      cb_distancia_out     <= '0;
      cb_ocupado_out       <= 1'b0;
      cb_encontrado_out    <= 1'b0;
      cb_falha_out         <= 1'b0;
      cb_iteracoes_out     <= '0;
    end else begin
      viz_req_out          <= viz_req_d;
      viz_endereco_out     <= viz_end_d;
      cb_atualizar_out     <= atu_d;
      cb_desativar_out     <= des_d;
      cb_endereco_out      <= end_d;
      cb_anterior_out      <= ant_d;
      cb_menor_vizinho_out <= custo_d;
      cb_distancia_out     <= dist_d;
      cb_ocupado_out       <= ocu_d;
      cb_encontrado_out    <= enc_d;
      cb_falha_out         <= fal_d;
      cb_iteracoes_out     <= it_d;
    end
  end

endmodule

// File: tb/tb_controlador_busca.sv
// Directed bench for controlador_busca: seed, expansion, saturation,
// timeout, overflow, mid-search reset/start and empty expansion.
module tb_controlador_busca;

  localparam int GAPC = 2;
  localparam int TO   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic [4:0]  origem_in, destino_in;
  logic [3:0]  aa_aprovado_in;
  logic [19:0] aa_endereco_in, aa_distancia_in;
  logic        viz_req_out;
  logic [4:0]  viz_endereco_out;
  logic        viz_valido_in, viz_ultimo_in;
  logic [4:0]  viz_endereco_in;
  logic [3:0]  viz_custo_in;
  logic        cb_atualizar_out, cb_desativar_out;
  logic [4:0]  cb_endereco_out, cb_anterior_out;
  logic [3:0]  cb_menor_vizinho_out;
  logic [4:0]  cb_distancia_out;
  logic        cb_ocupado_out, cb_encontrado_out, cb_falha_out;
  logic [7:0]  cb_iteracoes_out;

  controlador_busca dut (
    .clk(clk), .rst(rst), .start_in(start_in),
    .origem_in(origem_in), .destino_in(destino_in),
    .aa_aprovado_in(aa_aprovado_in),
    .aa_endereco_in(aa_endereco_in),
    .aa_distancia_in(aa_distancia_in),
    .viz_req_out(viz_req_out), .viz_endereco_out(viz_endereco_out),
    .viz_valido_in(viz_valido_in), .viz_endereco_in(viz_endereco_in),
    .viz_custo_in(viz_custo_in), .viz_ultimo_in(viz_ultimo_in),
    .cb_atualizar_out(cb_atualizar_out),
    .cb_desativar_out(cb_desativar_out),
    .cb_endereco_out(cb_endereco_out),
    .cb_anterior_out(cb_anterior_out),
    .cb_menor_vizinho_out(cb_menor_vizinho_out),
    .cb_distancia_out(cb_distancia_out),
    .cb_ocupado_out(cb_ocupado_out),
    .cb_encontrado_out(cb_encontrado_out),
    .cb_falha_out(cb_falha_out),
    .cb_iteracoes_out(cb_iteracoes_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int upd_adr[$], upd_ant[$], upd_dist[$], upd_custo[$], upd_cyc[$];
  int des_adr[$];
  int n_req = 0;
  int cyc = 0;
  int fal_cyc = 0;
  logic fal_q = 1'b0;

  logic [4:0] va[8];
  logic [3:0] vc[8];

  int b_upd, b_des, b_req;

  always @(negedge clk) begin
    cyc++;
    if (cb_atualizar_out) begin
      upd_adr.push_back(int'(cb_endereco_out));
      upd_ant.push_back(int'(cb_anterior_out));
      upd_dist.push_back(int'(cb_distancia_out));
      upd_custo.push_back(int'(cb_menor_vizinho_out));
      upd_cyc.push_back(cyc);
    end
    if (cb_desativar_out) des_adr.push_back(int'(cb_endereco_out));
    if (viz_req_out) n_req++;
    if (cb_falha_out && !fal_q) fal_cyc = cyc;
    fal_q = cb_falha_out;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    b_upd = upd_adr.size();
    b_des = des_adr.size();
    b_req = n_req;
  endtask

  task automatic go(input logic [4:0] o, input logic [4:0] d);
    mark();
    origem_in  = o;
    destino_in = d;
    start_in   = 1'b1;
    tick();
    start_in   = 1'b0;
  endtask

  task automatic slot0(input logic [4:0] a, input logic [4:0] dd);
    aa_aprovado_in  = 4'b0001;
    aa_endereco_in  = {15'd0, a};
    aa_distancia_in = {15'd0, dd};
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!viz_req_out && k < 100) begin
      tick();
      k++;
    end
    chk(tag, int'(viz_req_out), 1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (cb_ocupado_out && k < 300) begin
      tick();
      k++;
    end
    chk(tag, int'(cb_ocupado_out), 0);
    tick(2);
  endtask

  task automatic send(input int n);
    if (n == 0) begin
      viz_ultimo_in = 1'b1;
      tick();
    end
    for (int i = 0; i < n; i++) begin
      viz_valido_in   = 1'b1;
      viz_endereco_in = va[i];
      viz_custo_in    = vc[i];
      viz_ultimo_in   = (i == n - 1);
      tick();
    end
    viz_valido_in = 1'b0;
    viz_ultimo_in = 1'b0;
  endtask

  task automatic found_run(input string tag);
    slot0(5'd3, 5'd0);
    go(5'd3, 5'd3);
    wait_done({tag, "_done"});
    chk({tag, "_nupd"}, upd_adr.size() - b_upd, 1);
    chk({tag, "_seed_adr"}, upd_adr[b_upd], 3);
    chk({tag, "_seed_ant"}, upd_ant[b_upd], 3);
    chk({tag, "_seed_dist"}, upd_dist[b_upd], 0);
    chk({tag, "_nreq"}, n_req - b_req, 0);
    chk({tag, "_enc"}, int'(cb_encontrado_out), 1);
    chk({tag, "_fal"}, int'(cb_falha_out), 0);
    chk({tag, "_iter"}, int'(cb_iteracoes_out), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got 0 exp 1");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start_in = 1'b0;
    origem_in = '0;
    destino_in = '0;
    aa_aprovado_in = '0;
    aa_endereco_in = '0;
    aa_distancia_in = '0;
    viz_valido_in = 1'b0;
    viz_ultimo_in = 1'b0;
    viz_endereco_in = '0;
    viz_custo_in = '0;
    tick(3);
    chk("rst_ocupado", int'(cb_ocupado_out), 0);
    chk("rst_enc", int'(cb_encontrado_out), 0);
    chk("rst_fal", int'(cb_falha_out), 0);
    chk("rst_iter", int'(cb_iteracoes_out), 0);
    chk("rst_atu", int'(cb_atualizar_out), 0);
    rst = 1'b0;
    tick(2);

    // origin equals destination
    found_run("t1");

    // two neighbours, lowest approved slot is 1
    aa_aprovado_in  = 4'b0110;
    aa_endereco_in  = {5'd0, 5'd7, 5'd1, 5'd0};
    aa_distancia_in = {5'd0, 5'd2, 5'd0, 5'd0};
    go(5'd1, 5'd9);
    chk("t2_ocupado", int'(cb_ocupado_out), 1);
    wait_req("t2_req");
    chk("t2_viz_end", int'(viz_endereco_out), 1);
    aa_aprovado_in = '0;
    va[0] = 5'd2; vc[0] = 4'd3;
    va[1] = 5'd5; vc[1] = 4'd1;
    send(2);
    wait_done("t2_done");
    chk("t2_nupd", upd_adr.size() - b_upd, 3);
    chk("t2_u1_adr", upd_adr[b_upd+1], 2);
    chk("t2_u1_ant", upd_ant[b_upd+1], 1);
    chk("t2_u1_dist", upd_dist[b_upd+1], 3);
    chk("t2_u1_custo", upd_custo[b_upd+1], 3);
    chk("t2_u2_adr", upd_adr[b_upd+2], 5);
    chk("t2_u2_dist", upd_dist[b_upd+2], 1);
    chk("t2_gap", upd_cyc[b_upd+2] - upd_cyc[b_upd+1], GAPC + 1);
    chk("t2_ndes", des_adr.size() - b_des, 1);
    chk("t2_des_adr", des_adr[b_des], 1);
    chk("t2_iter", int'(cb_iteracoes_out), 1);
    chk("t2_fal", int'(cb_falha_out), 1);
    chk("t2_enc", int'(cb_encontrado_out), 0);

    // distance saturation 30 + 5 -> 31
    slot0(5'd1, 5'd30);
    go(5'd1, 5'd9);
    chk("t3_fal_clr", int'(cb_falha_out), 0);
    wait_req("t3_req");
    aa_aprovado_in = '0;
    va[0] = 5'd4; vc[0] = 4'd5;
    send(1);
    wait_done("t3_done");
    chk("t3_dist", upd_dist[b_upd+1], 31);
    chk("t3_ant", upd_ant[b_upd+1], 1);

    // no approval at all: timeout
    aa_aprovado_in = '0;
    go(5'd4, 5'd9);
    wait_done("t4_done");
    chk("t4_fal", int'(cb_falha_out), 1);
    chk("t4_nreq", n_req - b_req, 0);
    chk("t4_time", fal_cyc - upd_cyc[b_upd], GAPC + TO);

    // five beats into a four-entry FIFO
    slot0(5'd1, 5'd0);
    go(5'd1, 5'd9);
    wait_req("t5_req");
    aa_aprovado_in = '0;
    va[0] = 5'd6;  vc[0] = 4'd1;
    va[1] = 5'd7;  vc[1] = 4'd1;
    va[2] = 5'd8;  vc[2] = 4'd1;
    va[3] = 5'd10; vc[3] = 4'd1;
    va[4] = 5'd11; vc[4] = 4'd1;
    send(5);
    wait_done("t5_done");
    chk("t5_nupd", upd_adr.size() - b_upd, 5);
    chk("t5_last_adr", upd_adr[b_upd+4], 10);
    chk("t5_fal", int'(cb_falha_out), 1);
    chk("t5_iter", int'(cb_iteracoes_out), 1);

    // reset during neighbour updates
    slot0(5'd1, 5'd0);
    go(5'd1, 5'd9);
    wait_req("t6_req");
    aa_aprovado_in = '0;
    va[0] = 5'd2; vc[0] = 4'd3;
    va[1] = 5'd5; vc[1] = 4'd1;
    send(2);
    begin
      int k = 0;
      while (!cb_atualizar_out && k < 50) begin
        tick();
        k++;
      end
      chk("t6_first_upd", int'(cb_atualizar_out), 1);
    end
    rst = 1'b1;
    #1;
    chk("t6_rst_ocupado", int'(cb_ocupado_out), 0);
    chk("t6_rst_atu", int'(cb_atualizar_out), 0);
    chk("t6_rst_iter", int'(cb_iteracoes_out), 0);
    tick(2);
    rst = 1'b0;
    mark();
    tick(12);
    chk("t6_no_upd", upd_adr.size() - b_upd, 0);
    chk("t6_no_des", des_adr.size() - b_des, 0);
    found_run("t6r");

    // start mid-search ignored, zero-neighbour expansion
    slot0(5'd1, 5'd0);
    go(5'd1, 5'd9);
    begin
      int k = 0;
      while (!cb_atualizar_out && k < 50) begin
        tick();
        k++;
      end
      chk("t7_seed", int'(cb_atualizar_out), 1);
    end
    origem_in  = 5'd3;
    destino_in = 5'd1;
    start_in   = 1'b1;
    tick();
    start_in   = 1'b0;
    wait_req("t7_req");
    aa_aprovado_in = '0;
    send(0);
    wait_done("t7_done");
    chk("t7_enc", int'(cb_encontrado_out), 0);
    chk("t7_nreq", n_req - b_req, 1);
    chk("t7_nupd", upd_adr.size() - b_upd, 1);
    chk("t7_seed_adr", upd_adr[b_upd], 1);
    chk("t7_ndes", des_adr.size() - b_des, 1);
    chk("t7_des_adr", des_adr[b_des], 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
